// File: rtl/store_merge_unit_pkg.sv
// Shared definitions for the store merge unit: size encodings, FSM states
// and a helper that folds the reserved size code onto word stores.
package store_merge_unit_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ
    } state_t;

    // Reserved code 11 behaves exactly as a word store.
    function automatic logic [1:0] norm_size(input logic [1:0] s);
        return (s == 2'b11) ? SIZE_WORD : s;
    endfunction

endpackage

// File: rtl/store_merge_unit_lane_merge.sv
// store_lane_merge: combinational big-endian lane insert.
// Ports: i_old (memory word), i_data (store value), i_size, i_offset -> o_merged.
module store_lane_merge
    import store_merge_unit_pkg::*;
(
    input  logic [31:0] i_old,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    output logic [31:0] o_merged
);

    // Offset 0 is the most significant lane.
    always_comb begin
        o_merged = i_old;
        if (i_size == SIZE_BYTE) begin
            unique case (i_offset)
                2'd0: o_merged[31:24] = i_data[7:0];
                2'd1: o_merged[23:16] = i_data[7:0];
                2'd2: o_merged[15:8]  = i_data[7:0];
                default: o_merged[7:0] = i_data[7:0];
            endcase
        end else if (i_size == SIZE_HALF) begin
            if (i_offset[1]) begin
                o_merged[15:0] = i_data[15:0];
            end else begin
                o_merged[31:16] = i_data[15:0];
            end
        end else begin
            o_merged = i_data;
        end
    end

endmodule

// File: rtl/store_merge_unit.sv
// Store-side data path: SB/SH via read-modify-write, SW written directly.
// Ports: req_* store request, mem_* word memory port, done/misalign pulses.
// Optional: STORE_MISALIGN_TRAP_EN rejects misaligned SH/SW with a misalign pulse;
// when undefined, low address bits are forced to alignment.
module store_merge_unit
    import store_merge_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              done,
    output logic              misalign
);

    state_t            r_state;
    logic [1:0]        r_size;
    logic [ADDR_W-3:0] r_waddr;
    logic [1:0]        r_off;
    logic [31:0]       r_data;
    logic [31:0]       r_wdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic              r_done;
    logic              r_misalign;

    logic [1:0]        w_size;
    logic [1:0]        w_off;
    logic              w_trap;
    logic [31:0]       w_merged;

    assign w_size = norm_size(req_size);

    // Offset as seen by the lane merger, aligned to the access size.
    always_comb begin
        w_off = req_addr[1:0];
        if (w_size == SIZE_HALF) begin
            w_off[0] = 1'b0;
        end else if (w_size == SIZE_WORD) begin
            w_off = 2'b00;
        end
    end

`ifdef STORE_MISALIGN_TRAP_EN
    assign w_trap = ((w_size == SIZE_HALF) && req_addr[0]) ||
                    ((w_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_trap = 1'b0;
`endif

    store_lane_merge u_merge (
        .i_old    (mem_rdata),
        .i_data   (r_data),
        .i_size   (r_size),
        .i_offset (r_off),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_size     <= 2'b00;
            r_waddr    <= '0;
            r_off      <= 2'b00;
            r_data     <= '0;
            r_wdata    <= '0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_size  <= w_size;
                        r_waddr <= req_addr[ADDR_W-1:2];
                        r_off   <= w_off;
                        r_data  <= req_wdata;
                        if (w_trap) begin
                            r_misalign <= 1'b1;
                        end else if (w_size == SIZE_WORD) begin
                            r_wdata   <= req_wdata;
                            r_mem_req <= 1'b1;
                            r_mem_we  <= 1'b1;
                            r_state   <= ST_WR_REQ;
                        end else begin
                            r_mem_req <= 1'b1;
                            r_mem_we  <= 1'b0;
                            r_state   <= ST_RD_REQ;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rvalid) begin
                        r_wdata   <= w_merged;
                        r_mem_req <= 1'b1;
                        r_mem_we  <= 1'b1;
                        r_state   <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_waddr;
    assign mem_wdata = r_wdata;
    assign done      = r_done;
    assign misalign  = r_misalign;

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-side data path for the MIPS core's data memory: the counterpart of the load-side sign/zero extension. Accepts one store request per transaction (SB, SH or SW) with a byte address and a 32-bit register value, narrows the value to the requested size, and writes it into word-organised data memory. Word stores are written directly. Byte and halfword stores use read-modify-write so the untouched lanes are preserved. Sits between the MEM stage and the data-memory port.

## Interface
Parameters:
- ADDR_W, 32, byte-address width; memory word address is ADDR_W-2 bits

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  register value; only low 8/16 bits used for SB/SH
- mem_req  out  1  memory access request, held until mem_gnt
- mem_we  out  1  1 write, 0 read
- mem_addr  out  ADDR_W-2  word address
- mem_wdata  out  32  full word to write
- mem_gnt  in  1  memory accepts current request this cycle
- mem_rvalid  in  1  read data valid, earliest the cycle after read grant
- mem_rdata  in  32  read word
- done  out  1  one-cycle pulse, store completed
- misalign  out  1  one-cycle pulse, request rejected (see Configuration)

## Operation
- Lane order is big-endian: byte offset 0 = bits [31:24], offset 3 = [7:0]; halfword offset 0 = [31:16], offset 2 = [15:0].
- Request is captured into internal registers (size, word address, byte offset, data) on the cycle where req_valid && req_ready.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ.
  - IDLE: req_ready=1. Accepted word store goes to WR_REQ. Accepted byte or halfword store goes to RD_REQ.
  - RD_REQ: mem_req=1, mem_we=0, mem_addr=captured word address. Moves to RD_WAIT on mem_gnt.
  - RD_WAIT: waits for mem_rvalid. On mem_rvalid, the merged word is registered and the state moves to WR_REQ. The merged word is mem_rdata with the target lane replaced by req_wdata[7:0] or [15:0].
  - WR_REQ: mem_req=1, mem_we=1, mem_wdata=merged or full word. On mem_gnt, goes to IDLE and done pulses the next cycle.
- mem_rvalid outside RD_WAIT is ignored. mem_gnt outside RD_REQ and WR_REQ is ignored.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1.
- Reserved size 11 behaves exactly as size 10.

## Timing
- Reset values: req_ready=1 (state IDLE), mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, misalign=0. All internal registers are cleared.
- Reset mid-operation: on the next edge the state is IDLE and mem_req is 0. A pending read or write is abandoned and no done pulse is produced.
- Word store, zero-wait memory: accept at T, mem_req/we at T+1 with gnt, done at T+2. Latency is 2 cycles.
- Byte/halfword store, zero-wait memory (gnt same cycle, rvalid next cycle): accept T, read request T+1, rvalid T+2, write request T+3, done T+4. Latency is 4 cycles.
- Each cycle that mem_gnt is low extends the current request state by one cycle. Each cycle without mem_rvalid extends RD_WAIT by one cycle.
- Back-to-back: req_ready returns to 1 in the same cycle as done. Throughput is one store per 2 cycles (word) or 4 cycles (sub-word).
- done and misalign are never asserted in the same cycle.

## Configuration
- STORE_MISALIGN_TRAP_EN defined:
  - An SH with addr[0]=1, or an SW with addr[1:0]!=00, is accepted and produces a misalign pulse the following cycle.
  - No memory access is made and the state stays IDLE.
- STORE_MISALIGN_TRAP_EN undefined:
  - The low address bits are forced to alignment: SH clears addr[0], SW clears addr[1:0]. The store then proceeds normally.
  - misalign is tied to 0.

## Structure
- Shared package holds the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the state enum.
- One sub-module, store_lane_merge: purely combinational (old word, data, size, offset) -> merged word. It is reused by any later store-buffer work.

## Test plan
- Reset: rst high 2 cycles then low. req_ready=1, mem_req=0, done=0.
- SW: addr 0x0000_0010, data 0xDEADBEEF, zero-wait memory. mem_addr=0x4, mem_we=1, mem_wdata=0xDEADBEEF at T+1, done at T+2, no read issued.
- SB: addr 0x0000_0011, data 0x000000AB, memory word 0x11223344. Read of word 0x4, then write of 0x11AB3344, done at T+4.
- SH: addr 0x0000_0022, data 0x0000CAFE, memory word 0x55667788, mem_gnt stalled 3 cycles on the write. Write data is 0x5566CAFE and stays stable during the stall; done 3 cycles later than the zero-wait case.
- Misaligned SH: addr 0x0000_0003, data 0x00001234, memory word 0x11223344.
  - With STORE_MISALIGN_TRAP_EN: misalign pulse, no mem_req.
  - Without it: read and write go to word 0x0, written data 0x11221234.
- Reset asserted during RD_WAIT: mem_req=0 and state IDLE next edge. A late mem_rvalid is ignored and no done pulse is produced.
